// File: rtl/gpio_input_filter.sv
// Per-line GPIO conditioning: two-flop synchroniser, counter debounce, registered rise/fall pulses.
// Latency io_in -> din is 2 + max(filt_len,1) cycles; no backpressure, every line updates every cycle.
module gpio_input_filter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] io_in,
  input  logic [WIDTH-1:0] filter_en,
  input  logic [CNT_W-1:0] filt_len,
  output logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] din_q;
  logic [WIDTH-1:0] din_d;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [CNT_W:0]   len_ext;
  logic [CNT_W:0]   cnt_inc;

  assign len_ext = {1'b0, filt_len};

  // The extra compare bit keeps cnt+1 from wrapping, so filt_len of 0 or 1 degenerates to bypass.
  always_comb begin
    din_d   = din_q;
    cnt_inc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      cnt_inc  = {1'b0, cnt_q[i]} + {{CNT_W{1'b0}}, 1'b1};
      if (!filter_en[i]) begin
        din_d[i] = sync2_q[i];
      end else if (sync2_q[i] != din_q[i]) begin
        if (cnt_inc >= len_ext) begin
          din_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_inc[CNT_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      din_q   <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= io_in;
      sync2_q <= sync1_q;
      din_q   <= din_d;
      rise_q  <= din_d & ~din_q;
      fall_q  <= ~din_d & din_q;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign din  = din_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: tb/tb_gpio_input_filter.sv
// Directed bench for gpio_input_filter: expectations are queued per cycle and checked on the falling edge.
module tb_gpio_input_filter;

  logic        clk;
  logic        rst;
  logic [31:0] io_in;
  logic [31:0] filter_en;
  logic [7:0]  filt_len;
  logic [31:0] din;
  logic [31:0] rise;
  logic [31:0] fall;

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    int          cyc;
    logic [31:0] din;
    logic [31:0] rise;
    logic [31:0] fall;
    int          cline;
    logic [7:0]  cval;
  } exp_t;

  exp_t sb[$];

  gpio_input_filter #(.WIDTH(32), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .io_in     (io_in),
    .filter_en (filter_en),
    .filt_len  (filt_len),
    .din       (din),
    .rise      (rise),
    .fall      (fall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(string tag, int c, logic [31:0] d, logic [31:0] r,
                               logic [31:0] f, int cl = -1, logic [7:0] cv = 8'd0);
    exp_t e;
    e.tag = tag; e.cyc = c; e.din = d; e.rise = r; e.fall = f; e.cline = cl; e.cval = cv;
    sb.push_back(e);
  endfunction

  // din holds b for lat-1 cycles, switches to a at k+lat with the matching pulse, then settles.
  function automatic void expect_edge(string tag, int k, int lat, logic [31:0] b, logic [31:0] a);
    for (int c = 1; c < lat; c++) push(tag, k + c, b, 32'd0, 32'd0);
    push(tag, k + lat, a, a & ~b, b & ~a);
    push(tag, k + lat + 1, a, 32'd0, 32'd0);
  endfunction

  task automatic check(exp_t e);
    checks++;
    assert (din === e.din) else begin
      failures++;
      $error("FAIL %s din cyc=%0d observed=%h expected=%h", e.tag, cyc, din, e.din);
    end
    checks++;
    assert (rise === e.rise) else begin
      failures++;
      $error("FAIL %s rise cyc=%0d observed=%h expected=%h", e.tag, cyc, rise, e.rise);
    end
    checks++;
    assert (fall === e.fall) else begin
      failures++;
      $error("FAIL %s fall cyc=%0d observed=%h expected=%h", e.tag, cyc, fall, e.fall);
    end
    if (e.cline >= 0) begin
      checks++;
      assert (dut.cnt_q[e.cline] === e.cval) else begin
        failures++;
        $error("FAIL %s cnt[%0d] cyc=%0d observed=%0d expected=%0d",
               e.tag, e.cline, cyc, dut.cnt_q[e.cline], e.cval);
      end
    end
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        check(sb[i]);
        sb.delete(i);
      end
    end
  end

  task automatic wait_cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst       = 1'b1;
    io_in     = 32'hFFFF_FFFF;
    filter_en = 32'd0;
    filt_len  = 8'd0;
    for (int c = 1; c <= 3; c++) push("reset_hold", c, 32'd0, 32'd0, 32'd0, 0, 8'd0);
    wait_cyc(4);
    io_in = 32'd0;
    rst   = 1'b0;
    wait_cyc(2);

    // bypass: synchroniser only
    k = cyc; filt_len = 8'd5; io_in = 32'h1;
    expect_edge("bypass_rise", k, 3, 32'd0, 32'h1);
    wait_cyc(6);
    k = cyc; io_in = 32'd0;
    expect_edge("bypass_fall", k, 3, 32'h1, 32'd0);
    wait_cyc(6);

    // debounce with filt_len=5 on line 3
    k = cyc; filter_en = 32'hFFFF_FFFF; io_in = 32'h8;
    expect_edge("debounce_rise", k, 7, 32'd0, 32'h8);
    for (int j = 0; j <= 4; j++) push("debounce_cnt", k + 2 + j, 32'd0, 32'd0, 32'd0, 3, 8'(j));
    wait_cyc(9);
    k = cyc; io_in = 32'd0;
    expect_edge("debounce_fall", k, 7, 32'h8, 32'd0);
    wait_cyc(9);

    // glitch: 4 high cycles fall one short of filt_len
    k = cyc; io_in = 32'h8;
    for (int c = 1; c <= 10; c++) push("glitch", k + c, 32'd0, 32'd0, 32'd0);
    push("glitch_cnt", k + 6, 32'd0, 32'd0, 32'd0, 3, 8'd4);
    push("glitch_cnt", k + 7, 32'd0, 32'd0, 32'd0, 3, 8'd0);
    wait_cyc(4);
    io_in = 32'd0;
    wait_cyc(8);

    // concurrent: upper half bypassed, lower half filtered with filt_len=4
    k = cyc; filter_en = 32'h0000_FFFF; filt_len = 8'd4; io_in = 32'hFFFF_FFFF;
    for (int c = 1; c <= 7; c++)
      push("concurrent_rise", k + c,
           (c < 3) ? 32'd0 : (c < 6) ? 32'hFFFF_0000 : 32'hFFFF_FFFF,
           (c == 3) ? 32'hFFFF_0000 : (c == 6) ? 32'h0000_FFFF : 32'd0, 32'd0);
    wait_cyc(8);
    k = cyc; io_in = 32'd0;
    for (int c = 1; c <= 7; c++)
      push("concurrent_fall", k + c,
           (c < 3) ? 32'hFFFF_FFFF : (c < 6) ? 32'h0000_FFFF : 32'd0, 32'd0,
           (c == 3) ? 32'hFFFF_0000 : (c == 6) ? 32'h0000_FFFF : 32'd0);
    wait_cyc(8);

    // filt_len=255: counter tops out at 254, no wrap
    k = cyc; filter_en = 32'hFFFF_FFFF; filt_len = 8'd255; io_in = 32'h1;
    expect_edge("len255", k, 257, 32'd0, 32'h1);
    push("len255_cnt", k + 2, 32'd0, 32'd0, 32'd0, 0, 8'd0);
    push("len255_cnt", k + 256, 32'd0, 32'd0, 32'd0, 0, 8'd254);
    push("len255_cnt", k + 257, 32'h1, 32'h1, 32'd0, 0, 8'd0);
    wait_cyc(259);
    k = cyc; filt_len = 8'd0; io_in = 32'd0;
    expect_edge("len0_fall", k, 3, 32'h1, 32'd0);
    wait_cyc(5);
    k = cyc; filt_len = 8'd1; io_in = 32'h1;
    expect_edge("len1_rise", k, 3, 32'd0, 32'h1);
    wait_cyc(5);
    k = cyc; io_in = 32'd0;
    expect_edge("len1_fall", k, 3, 32'h1, 32'd0);
    wait_cyc(5);

    // filt_len lowered mid-count to cnt+1 releases din on the next edge
    k = cyc; filt_len = 8'd10; io_in = 32'h1;
    expect_edge("len_drop", k, 5, 32'd0, 32'h1);
    push("len_drop_cnt", k + 4, 32'd0, 32'd0, 32'd0, 0, 8'd2);
    wait_cyc(4);
    filt_len = 8'd3;
    wait_cyc(3);
    k = cyc; filt_len = 8'd0; io_in = 32'd0;
    expect_edge("len_drop_fall", k, 3, 32'h1, 32'd0);
    wait_cyc(5);

    // filter_en dropped mid-count: count discarded, din follows sync2
    k = cyc; filt_len = 8'd10; io_in = 32'h1;
    expect_edge("en_drop", k, 5, 32'd0, 32'h1);
    push("en_drop_cnt", k + 5, 32'h1, 32'h1, 32'd0, 0, 8'd0);
    wait_cyc(4);
    filter_en = 32'd0;
    wait_cyc(3);
    k = cyc; filter_en = 32'hFFFF_FFFF; filt_len = 8'd0; io_in = 32'd0;
    expect_edge("en_drop_fall", k, 3, 32'h1, 32'd0);
    wait_cyc(5);

    // reset mid-count, released with io_in high
    k = cyc; filt_len = 8'd5; io_in = 32'h1;
    for (int c = 1; c <= 7; c++) push("rst_mid", k + c, 32'd0, 32'd0, 32'd0);
    push("rst_mid_cnt", k + 3, 32'd0, 32'd0, 32'd0, 0, 8'd1);
    push("rst_mid_cnt", k + 5, 32'd0, 32'd0, 32'd0, 0, 8'd0);
    expect_edge("rst_release", k + 7, 7, 32'd0, 32'h1);
    wait_cyc(4);
    rst = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(10);

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpio_input_filter.md
GPIO_INPUT_FILTER -- requirements
Module: gpio_input_filter

Interface
REQ-001 Parameter WIDTH, default 32, number of GPIO input lines filtered.
REQ-002 Parameter CNT_W, default 8, width of the per-line stability counter and of filt_len.
REQ-003 clk  input  1  single block clock, rising-edge active.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 io_in  input  WIDTH  raw asynchronous pad inputs.
REQ-006 filter_en  input  WIDTH  per-line filter enable: 1 = debounce, 0 = synchronise only.
REQ-007 filt_len  input  CNT_W  required consecutive stable cycles, quasi-static, shared by all lines.
REQ-008 din  output  WIDTH  conditioned input value, drives the GPIO peripheral input bus.
REQ-009 rise  output  WIDTH  one-cycle pulse per line on a din 0->1 transition.
REQ-010 fall  output  WIDTH  one-cycle pulse per line on a din 1->0 transition.

Function
REQ-011 Each line SHALL pass through a two-flop synchroniser (sync1 -> sync2) before any other logic.
REQ-012 Each line SHALL own a CNT_W-bit counter cnt[i] and a registered output din[i].
REQ-013 When sync2[i] == din[i], cnt[i] SHALL be cleared to 0 on the next edge.
REQ-014 When sync2[i] != din[i] and filter_en[i]=1: if cnt[i]+1 >= filt_len, din[i] SHALL take sync2[i] and cnt[i] SHALL clear; otherwise cnt[i] SHALL increment by 1.
REQ-015 The >= comparison SHALL use CNT_W+1-bit arithmetic; cnt[i] SHALL never wrap or exceed filt_len-1.
REQ-016 When filter_en[i]=0, din[i] SHALL take sync2[i] every cycle and cnt[i] SHALL be held at 0.
REQ-017 filt_len = 0 and filt_len = 1 SHALL both behave identically to filter_en[i]=0.
REQ-018 Latency from an io_in edge (meeting setup) to the din change SHALL be 2 + max(filt_len,1) clock cycles.
REQ-019 A mismatch interrupted by even one matching cycle SHALL restart counting from 0 (glitch rejection).
REQ-020 Changing filt_len mid-count SHALL take effect on the next cycle via REQ-014; a lowered filt_len at or below cnt+1 SHALL update din on that edge.
REQ-021 Toggling filter_en[i] 1->0 mid-count SHALL discard the count; din[i] SHALL follow sync2[i] on the next edge.
REQ-022 rise[i] and fall[i] SHALL be registered and asserted for exactly the one cycle after the edge on which din[i] changes; they SHALL never be asserted together.
REQ-023 Lines SHALL be fully independent; simultaneous changes on any lines SHALL be processed in parallel.

Reset
REQ-024 While rst=1: sync1, sync2, din, cnt, rise and fall SHALL all be 0, asynchronously.
REQ-025 After rst deasserts with io_in high, din SHALL rise per REQ-018 and rise SHALL pulse once.
REQ-026 Reset asserted mid-count SHALL abort the count immediately with no pulse on rise/fall.

Verification
REQ-027 Bypass: filter_en=0, io_in[0] 0->1 -> din[0]=1 exactly 3 cycles later; rise[0] high for 1 cycle, fall[0] never asserted.
REQ-028 Debounce: filter_en=all-ones, filt_len=5, io_in[3] 0->1 held -> din[3]=1 at cycle 7; cnt[3] reads 0,1,2,3,4 over the preceding cycles.
REQ-029 Glitch: filt_len=5, io_in[3] high for 4 cycles then low -> din[3] stays 0, rise[3] never asserted.
REQ-030 Boundary: filt_len=255 with CNT_W=8, held change -> din updates after 257 cycles with no counter wrap; filt_len=0 -> 3-cycle latency.
REQ-031 Concurrent: io_in 0x0000_0000 -> 0xFFFF_FFFF with filter_en=0x0000_FFFF, filt_len=4 -> din upper 16 bits set at cycle 3, lower 16 bits set at cycle 6.
REQ-032 Reset: rst=1 asserted mid-count, then released with io_in=0x1 -> all outputs read 0 during reset; din[0]=1 after REQ-018 latency with a single rise[0] pulse.
